// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side signals of the two-port RAM arbiter.
// slave  = the arbiter; master = requesters plus the ram32x4 instance.
interface ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
               ram_address, ram_data, ram_wren, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
               ram_address, ram_data, ram_wren, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters sharing one ram32x4. After reset the RAM is
// swept to zero (CLEAR), then single-cycle accesses are granted (SERVE).
// Optional macro RAM_ARBITER_RR_EN: round-robin on conflict; when undefined,
// port 0 has fixed priority and no last-grant pointer exists.
//
// state | meaning
// CLEAR | writing 0 to address r_cnt, busy=1, no grants
// SERVE | arbitrating requests, one RAM access per cycle
module ram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic         clock,
    input  logic         resetn,
    ram_arbiter_if.slave bus
);
    typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_busy;
    logic              w_wren;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
`ifdef RAM_ARBITER_RR_EN
    logic              r_last;   // 1 = port 1 was granted most recently
`endif

    // Arbitration: at most one grant, only in SERVE and only to a requester
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == SERVE) begin
`ifdef RAM_ARBITER_RR_EN
            if (bus.req0 && bus.req1) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = bus.req0;
                w_gnt1 = bus.req1;
            end
`else
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1 & ~bus.req0;
`endif
        end
    end

    // Next state and RAM port drive; idle cycles present zeros to the RAM
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_wren      = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                w_wren = 1'b1;
                w_addr = r_cnt;
                if (r_cnt == '1) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (w_gnt0) begin
                    w_wren = bus.we0;
                    w_addr = bus.addr0;
                    w_data = bus.wdata0;
                end else if (w_gnt1) begin
                    w_wren = bus.we1;
                    w_addr = bus.addr1;
                    w_data = bus.wdata1;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // State, sweep counter and read-valid flags (RAM q lands one cycle later)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;   // wraps back to 0 as the sweep ends
            end
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
        end
    end

`ifdef RAM_ARBITER_RR_EN
    // Last-grant pointer; reset value makes port 0 win the first conflict
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end
`endif

    assign bus.gnt0        = w_gnt0;
    assign bus.gnt1        = w_gnt1;
    assign bus.rvalid0     = r_rvalid0;
    assign bus.rvalid1     = r_rvalid1;
    assign bus.rdata       = bus.ram_q;
    assign bus.ram_address = w_addr;
    assign bus.ram_data    = w_data;
    assign bus.ram_wren    = w_wren;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a scoreboard monitor for ram_arbiter.
module tb_ram_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;

    logic       clock = 1'b0;
    logic       resetn;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] rd_q[$];     // {port, data}
    logic [8:0] wr_q[$];     // {addr, data}
    logic [3:0] mem [32];
    bit         ram_init = 1'b0;
    int         exp_g [4];

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    always #5 clock = ~clock;

    // ram32x4 model: registered address, old data on q, nonzero power-up
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 4'(i) ^ 4'h5;
            ram_init  <= 1'b1;
            ifc.ram_q <= '0;
        end else begin
            if (ifc.ram_wren) mem[ifc.ram_address] <= ifc.ram_data;
            ifc.ram_q <= mem[ifc.ram_address];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ifc.req0 = 1'b0; ifc.we0 = 1'b0; ifc.addr0 = '0; ifc.wdata0 = '0;
        ifc.req1 = 1'b0; ifc.we1 = 1'b0; ifc.addr1 = '0; ifc.wdata1 = '0;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) wr_q.push_back({5'(i), 4'h0});
    endtask

    // Monitor: pops expected RAM writes and read returns as the DUT shows them
    always @(negedge clock) begin
        if (resetn) begin
            logic [4:0] er;
            logic [8:0] ew;
            chk("gnt_excl", {31'd0, ifc.gnt0 & ifc.gnt1}, 32'd0);
            if (ifc.rvalid0 || ifc.rvalid1) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_unexpected: got rvalid %b%b expected none", ifc.rvalid1, ifc.rvalid0);
                end else begin
                    er = rd_q.pop_front();
                    chk("rd_port", {30'd0, ifc.rvalid1, ifc.rvalid0}, er[4] ? 32'd2 : 32'd1);
                    chk("rd_data", {28'd0, ifc.rdata}, {28'd0, er[3:0]});
                end
            end
            if (ifc.ram_wren) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_unexpected: got write %0h<=%0h expected none", ifc.ram_address, ifc.ram_data);
                end else begin
                    ew = wr_q.pop_front();
                    chk("wr_addr", {27'd0, ifc.ram_address}, {27'd0, ew[8:4]});
                    chk("wr_data", {28'd0, ifc.ram_data}, {28'd0, ew[3:0]});
                end
            end else if (!ifc.gnt0 && !ifc.gnt1 && !ifc.busy) begin
                chk("idle_bus", {23'd0, ifc.ram_address, ifc.ram_data}, 32'd0);
            end
        end
    end

    initial begin
`ifdef RAM_ARBITER_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        resetn = 1'b0;
        idle();
        ifc.req1 = 1'b1; ifc.addr1 = 5'd7;       // read 7, held through CLEAR
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd1);
        chk("rst_gnt1", {31'd0, ifc.gnt1}, 32'd0);
        chk("rst_rvalid", {30'd0, ifc.rvalid0, ifc.rvalid1}, 32'd0);
        push_sweep();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            chk("clr_busy", {31'd0, ifc.busy}, 32'd1);
            chk("clr_gnt1", {31'd0, ifc.gnt1}, 32'd0);
        end
        @(negedge clock);
        chk("serve_busy", {31'd0, ifc.busy}, 32'd0);
        chk("first_gnt1", {31'd0, ifc.gnt1}, 32'd1);
        rd_q.push_back({1'b1, 4'h0});
        step();
        idle();

        // port 0 writes A to 5, port 1 reads it back
        ifc.req0 = 1'b1; ifc.we0 = 1'b1; ifc.addr0 = 5'd5; ifc.wdata0 = 4'hA;
        wr_q.push_back({5'd5, 4'hA});
        @(negedge clock);
        chk("wr_gnt0", {31'd0, ifc.gnt0}, 32'd1);
        chk("wr_gnt1", {31'd0, ifc.gnt1}, 32'd0);
        step();
        idle();
        ifc.req1 = 1'b1; ifc.addr1 = 5'd5;
        @(negedge clock);
        chk("rd_gnt1", {31'd0, ifc.gnt1}, 32'd1);
        rd_q.push_back({1'b1, 4'hA});
        step();
        idle();
        step();

        // conflict: port 0 writes 1 to 10, port 1 reads 5
        ifc.req0 = 1'b1; ifc.we0 = 1'b1; ifc.addr0 = 5'd10; ifc.wdata0 = 4'h1;
        ifc.req1 = 1'b1; ifc.addr1 = 5'd5;
        for (int k = 0; k < 4; k++) begin
            if (exp_g[k] == 0) wr_q.push_back({5'd10, 4'h1});
            @(negedge clock);
            chk("cfl_gnt0", {31'd0, ifc.gnt0}, (exp_g[k] == 0) ? 32'd1 : 32'd0);
            chk("cfl_gnt1", {31'd0, ifc.gnt1}, (exp_g[k] == 1) ? 32'd1 : 32'd0);
            if (exp_g[k] == 1) rd_q.push_back({1'b1, 4'hA});
            step();
        end
        idle();
        step();

        // read by port 0, then reset mid-read
        ifc.req0 = 1'b1; ifc.addr0 = 5'd5;
        @(negedge clock);
        chk("mid_gnt0", {31'd0, ifc.gnt0}, 32'd1);
        step();
        idle();
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_rvalid0", {31'd0, ifc.rvalid0}, 32'd0);
        chk("abort_busy", {31'd0, ifc.busy}, 32'd1);
        wr_q.delete();
        step();
        push_sweep();
        resetn = 1'b1;

        // reset again part-way through the sweep; it must restart at 0
        repeat (10) @(negedge clock);
        step();
        resetn = 1'b0;
        @(negedge clock);
        chk("sweep_abort_busy", {31'd0, ifc.busy}, 32'd1);
        wr_q.delete();
        push_sweep();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            chk("clr2_busy", {31'd0, ifc.busy}, 32'd1);
        end
        @(negedge clock);
        chk("serve2_busy", {31'd0, ifc.busy}, 32'd0);

        // back-to-back reads of cleared words
        step();
        ifc.req0 = 1'b1; ifc.addr0 = 5'd5;
        @(negedge clock);
        chk("b2b_gnt0", {31'd0, ifc.gnt0}, 32'd1);
        rd_q.push_back({1'b0, 4'h0});
        step();
        idle();
        ifc.req1 = 1'b1; ifc.addr1 = 5'd7;
        @(negedge clock);
        chk("b2b_gnt1", {31'd0, ifc.gnt1}, 32'd1);
        rd_q.push_back({1'b1, 4'h0});
        step();
        idle();
        repeat (3) @(negedge clock);

        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("wr_q_drained", wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
